// File: rtl/gg_deblock_writeback.sv
// rtl/gg_deblock_writeback.sv - compacting block write-back FIFO behind the deblocker
// Optional per-plane pop counters and level high-water mark: GG_DEBLOCK_WB_STATS_EN
module gg_deblock_writeback #(
    parameter int BIT_DEPTH  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int COORD_W    = 12
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            frame_start,
    input  logic [7:0]                      mbx,
    input  logic [7:0]                      mby,
    input  logic                            in_valid,
    input  logic [2:0]                      cidx,
    input  logic [3:0]                      bidx,
    input  logic                            ale_valid,
    input  logic                            abv_valid,
    input  logic                            lef_valid,
    input  logic                            cur_valid,
    input  logic [16*BIT_DEPTH-1:0]         ale_filt,
    input  logic [16*BIT_DEPTH-1:0]         abv_filt,
    input  logic [16*BIT_DEPTH-1:0]         lef_filt,
    input  logic [16*BIT_DEPTH-1:0]         cur_filt,
    output logic                            in_ready,
    output logic                            wr_valid,
    input  logic                            wr_ready,
    output logic [1:0]                      wr_plane,
    output logic [COORD_W-1:0]              wr_x,
    output logic [COORD_W-1:0]              wr_y,
    output logic [16*BIT_DEPTH-1:0]         wr_data,
    output logic                            overflow_err,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
`ifdef GG_DEBLOCK_WB_STATS_EN
    ,
    output logic [15:0]                     stat_y,
    output logic [15:0]                     stat_cb,
    output logic [15:0]                     stat_cr,
    output logic [$clog2(FIFO_DEPTH):0]     stat_hwm
`endif
);
    localparam int DW = 16 * BIT_DEPTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [COORD_W-1:0] FOUR = COORD_W'(4);

    logic [1:0]         mem_plane [FIFO_DEPTH];
    logic [COORD_W-1:0] mem_x     [FIFO_DEPTH];
    logic [COORD_W-1:0] mem_y     [FIFO_DEPTH];
    logic [DW-1:0]      mem_data  [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;

    logic               luma, cidx_ok;
    logic [1:0]         plane;
    logic [COORD_W-1:0] cx, cy;
    logic [3:0]         flags;
    logic [COORD_W-1:0] e_x [4];
    logic [COORD_W-1:0] e_y [4];
    logic [DW-1:0]      e_data [4];
    logic [COORD_W-1:0] p_x [4];
    logic [COORD_W-1:0] p_y [4];
    logic [DW-1:0]      p_data [4];
    logic [AW-1:0]      widx [4];
    logic [2:0]         npush;
    logic [PW-1:0]      level, free, rd_nxt, wr_nxt, lvl_nxt, hdiff;
    logic               push_req, push_ok, drop, pop, head_new;

    always_comb begin
        luma    = (cidx == 3'd0);
        cidx_ok = luma || (cidx == 3'd2) || (cidx == 3'd3);
        plane   = luma ? 2'd0 : ((cidx == 3'd2) ? 2'd1 : 2'd2);
        if (luma) begin
            cx = (COORD_W'(mbx) << 4) + (COORD_W'({bidx[2], bidx[0]}) << 2);
            cy = (COORD_W'(mby) << 4) + (COORD_W'({bidx[3], bidx[1]}) << 2);
        end else begin
            cx = (COORD_W'(mbx) << 3) + (COORD_W'(bidx[0]) << 2);
            cy = (COORD_W'(mby) << 3) + (COORD_W'(bidx[1]) << 2);
        end
        flags = {cur_valid, lef_valid, abv_valid, ale_valid};
        e_x[0] = cx - FOUR; e_y[0] = cy - FOUR; e_data[0] = ale_filt;
        e_x[1] = cx;        e_y[1] = cy - FOUR; e_data[1] = abv_filt;
        e_x[2] = cx - FOUR; e_y[2] = cy;        e_data[2] = lef_filt;
        e_x[3] = cx;        e_y[3] = cy;        e_data[3] = cur_filt;
    end

    // Pack the flagged entries into consecutive slots, keeping ale/abv/lef/cur order
    always_comb begin
        npush = '0;
        for (int j = 0; j < 4; j++) begin
            p_x[j]    = '0;
            p_y[j]    = '0;
            p_data[j] = '0;
            widx[j]   = AW'(wr_ptr + PW'(j));
        end
        for (int k = 0; k < 4; k++) begin
            if (flags[k]) begin
                p_x[npush[1:0]]    = e_x[k];
                p_y[npush[1:0]]    = e_y[k];
                p_data[npush[1:0]] = e_data[k];
                npush              = npush + 3'd1;
            end
        end
    end

    always_comb begin
        level    = wr_ptr - rd_ptr;
        free     = PW'(FIFO_DEPTH) - level;
        push_req = in_valid && cidx_ok && (npush != 3'd0);
        push_ok  = push_req && (PW'(npush) <= free);
        drop     = push_req && !push_ok;
        pop      = wr_valid && wr_ready;
        rd_nxt   = rd_ptr + PW'(pop);
        wr_nxt   = wr_ptr + (push_ok ? PW'(npush) : '0);
        lvl_nxt  = wr_nxt - rd_nxt;
        // The next head may be one of the entries being written this very cycle
        hdiff    = rd_nxt - wr_ptr;
        head_new = push_ok && (hdiff < PW'(npush));
    end

    assign fifo_level = level;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            for (int j = 0; j < 4; j++) begin
                if (3'(j) < npush) begin
                    mem_plane[widx[j]] <= plane;
                    mem_x[widx[j]]     <= p_x[j];
                    mem_y[widx[j]]     <= p_y[j];
                    mem_data[widx[j]]  <= p_data[j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            wr_valid     <= 1'b0;
            wr_plane     <= '0;
            wr_x         <= '0;
            wr_y         <= '0;
            wr_data      <= '0;
            in_ready     <= 1'b1;
            overflow_err <= 1'b0;
        end else begin
            wr_ptr   <= wr_nxt;
            rd_ptr   <= rd_nxt;
            wr_valid <= (lvl_nxt != '0);
            in_ready <= ((PW'(FIFO_DEPTH) - lvl_nxt) >= PW'(4));
            if (head_new) begin
                wr_plane <= plane;
                wr_x     <= p_x[hdiff[1:0]];
                wr_y     <= p_y[hdiff[1:0]];
                wr_data  <= p_data[hdiff[1:0]];
            end else begin
                wr_plane <= mem_plane[rd_nxt[AW-1:0]];
                wr_x     <= mem_x[rd_nxt[AW-1:0]];
                wr_y     <= mem_y[rd_nxt[AW-1:0]];
                wr_data  <= mem_data[rd_nxt[AW-1:0]];
            end
            if (drop)
                overflow_err <= 1'b1;
            else if (frame_start)
                overflow_err <= 1'b0;
        end
    end

`ifdef GG_DEBLOCK_WB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_y   <= '0;
            stat_cb  <= '0;
            stat_cr  <= '0;
            stat_hwm <= '0;
        end else if (frame_start) begin
            stat_y   <= '0;
            stat_cb  <= '0;
            stat_cr  <= '0;
            stat_hwm <= '0;
        end else begin
            if (pop) begin
                case (wr_plane)
                    2'd0:    if (stat_y  != 16'hFFFF) stat_y  <= stat_y  + 16'd1;
                    2'd1:    if (stat_cb != 16'hFFFF) stat_cb <= stat_cb + 16'd1;
                    default: if (stat_cr != 16'hFFFF) stat_cr <= stat_cr + 16'd1;
                endcase
            end
            if (lvl_nxt > stat_hwm)
                stat_hwm <= lvl_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_gg_deblock_writeback.sv
// tb/tb_gg_deblock_writeback.sv - self-checking bench for gg_deblock_writeback
// Stats ports exercised when GG_DEBLOCK_WB_STATS_EN is defined
module tb_gg_deblock_writeback;
    localparam int BD    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 12;
    localparam int DW    = 16 * BD;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          frame_start = 1'b0;
    logic [7:0]    mbx = '0, mby = '0;
    logic          in_valid = 1'b0;
    logic [2:0]    cidx = '0;
    logic [3:0]    bidx = '0;
    logic          ale_valid = 1'b0, abv_valid = 1'b0, lef_valid = 1'b0, cur_valid = 1'b0;
    logic [DW-1:0] ale_filt = '0, abv_filt = '0, lef_filt = '0, cur_filt = '0;
    logic          in_ready, wr_valid;
    logic          wr_ready = 1'b1;
    logic [1:0]    wr_plane;
    logic [CW-1:0] wr_x, wr_y;
    logic [DW-1:0] wr_data;
    logic          overflow_err;
    logic [LW-1:0] fifo_level;
`ifdef GG_DEBLOCK_WB_STATS_EN
    logic [15:0]   stat_y, stat_cb, stat_cr;
    logic [LW-1:0] stat_hwm;
`endif

    gg_deblock_writeback #(.BIT_DEPTH(BD), .FIFO_DEPTH(DEPTH), .COORD_W(CW)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .mbx(mbx), .mby(mby), .in_valid(in_valid), .cidx(cidx), .bidx(bidx),
        .ale_valid(ale_valid), .abv_valid(abv_valid), .lef_valid(lef_valid), .cur_valid(cur_valid),
        .ale_filt(ale_filt), .abv_filt(abv_filt), .lef_filt(lef_filt), .cur_filt(cur_filt),
        .in_ready(in_ready), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_plane(wr_plane), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .overflow_err(overflow_err), .fifo_level(fifo_level)
`ifdef GG_DEBLOCK_WB_STATS_EN
        , .stat_y(stat_y), .stat_cb(stat_cb), .stat_cr(stat_cr), .stat_hwm(stat_hwm)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    plane;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [DW-1:0] data;
    } ent_t;

    ent_t q[$];
    bit   m_ovf = 1'b0;
    int   m_sy = 0, m_scb = 0, m_scr = 0, m_hwm = 0;
    int   passed = 0, total = 0;
    bit   checking = 1'b0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [DW-1:0] pat(input int tag, input int k);
        logic [31:0] w;
        w = 32'(tag * 4 + k) * 32'h9E37_79B1 + 32'h1234_5678;
        return {w, ~w, w ^ 32'hFFFF_0000, w + 32'd7};
    endfunction

    // k: 0 = above-left, 1 = above, 2 = left, 3 = current
    function automatic ent_t mk(input int k, input int mx, input int my, input int ci,
                                input int bi, input logic [DW-1:0] d);
        ent_t e;
        int s, bx, by, x, y;
        if (ci == 0) begin
            s = 16; e.plane = 2'd0;
            bx = ((bi >> 2) & 1) * 2 + (bi & 1);
            by = ((bi >> 3) & 1) * 2 + ((bi >> 1) & 1);
        end else begin
            s = 8; e.plane = (ci == 2) ? 2'd1 : 2'd2;
            bx = bi & 1;
            by = (bi >> 1) & 1;
        end
        x = mx * s + bx * 4;
        y = my * s + by * 4;
        if (k == 0 || k == 2) x = x - 4;
        if (k == 0 || k == 1) y = y - 4;
        e.x = CW'(x); e.y = CW'(y); e.data = d;
        return e;
    endfunction

    bit            mp;
    int            mn;
    logic [3:0]    mfl;
    logic [DW-1:0] md [4];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_ovf = 1'b0;
            m_sy = 0; m_scb = 0; m_scr = 0; m_hwm = 0;
        end else begin
            mp  = (q.size() > 0) && wr_ready;
            mfl = {cur_valid, lef_valid, abv_valid, ale_valid};
            md[0] = ale_filt; md[1] = abv_filt; md[2] = lef_filt; md[3] = cur_filt;
            mn  = $countones(mfl);
            if (frame_start) m_ovf = 1'b0;
            if (mp) begin
                if (q[0].plane == 2'd0) m_sy = (m_sy < 65535) ? m_sy + 1 : m_sy;
                else if (q[0].plane == 2'd1) m_scb = (m_scb < 65535) ? m_scb + 1 : m_scb;
                else m_scr = (m_scr < 65535) ? m_scr + 1 : m_scr;
            end
            if (in_valid && (cidx == 3'd0 || cidx == 3'd2 || cidx == 3'd3) && mn > 0) begin
                if (mn > DEPTH - q.size()) begin
                    m_ovf = 1'b1;
                    mn = 0;
                end
            end else begin
                mn = 0;
            end
            if (mp) void'(q.pop_front());
            if (mn > 0)
                for (int k = 0; k < 4; k++)
                    if (mfl[k]) q.push_back(mk(k, int'(mbx), int'(mby), int'(cidx), int'(bidx), md[k]));
            if (frame_start) begin
                m_sy = 0; m_scb = 0; m_scr = 0; m_hwm = 0;
            end else if (q.size() > m_hwm) begin
                m_hwm = q.size();
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("wr_valid", DW'(wr_valid), DW'(q.size() > 0));
            chk("fifo_level", DW'(fifo_level), DW'(q.size()));
            chk("in_ready", DW'(in_ready), DW'((DEPTH - q.size()) >= 4));
            chk("overflow_err", DW'(overflow_err), DW'(m_ovf));
            if (q.size() > 0) begin
                chk("wr_plane", DW'(wr_plane), DW'(q[0].plane));
                chk("wr_x", DW'(wr_x), DW'(q[0].x));
                chk("wr_y", DW'(wr_y), DW'(q[0].y));
                chk("wr_data", wr_data, q[0].data);
            end
`ifdef GG_DEBLOCK_WB_STATS_EN
            chk("stat_y", DW'(stat_y), DW'(m_sy));
            chk("stat_cb", DW'(stat_cb), DW'(m_scb));
            chk("stat_cr", DW'(stat_cr), DW'(m_scr));
            chk("stat_hwm", DW'(stat_hwm), DW'(m_hwm));
`endif
        end
    end

    task automatic push(input int mx, input int my, input int ci, input int bi,
                        input logic [3:0] fl, input int tag);
        mbx = 8'(mx); mby = 8'(my); cidx = 3'(ci); bidx = 4'(bi);
        {cur_valid, lef_valid, abv_valid, ale_valid} = fl;
        ale_filt = pat(tag, 0); abv_filt = pat(tag, 1);
        lef_filt = pat(tag, 2); cur_filt = pat(tag, 3);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        {cur_valid, lef_valid, abv_valid, ale_valid} = 4'b0000;
    endtask

    int ex[4] = '{0, 4, 0, 4};
    int ey[4] = '{0, 0, 4, 4};

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_valid", DW'(wr_valid), DW'(0));
        chk("rst_in_ready", DW'(in_ready), DW'(1));
        chk("rst_wr_x", DW'(wr_x), DW'(0));
        chk("rst_wr_data", wr_data, DW'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        checking = 1'b1;
        @(negedge clk);
        chk("idle_level", DW'(fifo_level), DW'(0));

        // single luma current block
        push(1, 2, 0, 5, 4'b1000, 1);
        @(negedge clk);
        chk("t2_valid", DW'(wr_valid), DW'(1));
        chk("t2_plane", DW'(wr_plane), DW'(0));
        chk("t2_x", DW'(wr_x), DW'(28));
        chk("t2_y", DW'(wr_y), DW'(32));
        chk("t2_data", wr_data, pat(1, 3));
        @(negedge clk);
        chk("t2_empty", DW'(wr_valid), DW'(0));

        // all four chroma flags drain in fixed order
        push(0, 0, 2, 3, 4'b1111, 2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_plane", DW'(wr_plane), DW'(1));
            chk("t3_x", DW'(wr_x), DW'(ex[i]));
            chk("t3_y", DW'(wr_y), DW'(ey[i]));
            chk("t3_data", wr_data, pat(2, i));
        end
        @(negedge clk);
        chk("t3_empty", DW'(wr_valid), DW'(0));

        // fill with the sink stalled, then overflow
        wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(3, 1, 0, i * 5, 4'b1111, 10 + i);
            @(negedge clk);
            chk("t4_level", DW'(fifo_level), DW'(4 * (i + 1)));
            chk("t4_in_ready", DW'(in_ready), DW'(i < 3));
        end
        push(3, 1, 0, 1, 4'b1111, 20);
        @(negedge clk);
        chk("t4_drop_level", DW'(fifo_level), DW'(16));
        chk("t4_ovf", DW'(overflow_err), DW'(1));
        frame_start = 1'b1;
        push(3, 1, 0, 2, 4'b1000, 21);
        frame_start = 1'b0;
        @(negedge clk);
        chk("t4_set_wins", DW'(overflow_err), DW'(1));
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(negedge clk);
        chk("t4_ovf_clear", DW'(overflow_err), DW'(0));
        @(posedge clk); #1;
        wr_ready = 1'b1;
        repeat (16) @(negedge clk);
        @(negedge clk);
        chk("t4_drained", DW'(fifo_level), DW'(0));
`ifdef GG_DEBLOCK_WB_STATS_EN
        chk("t4_hwm", DW'(stat_hwm), DW'(16));
        chk("t4_stat_y", DW'(stat_y), DW'(16));
`endif

        // steady one-in one-out
        for (int i = 0; i < 10; i++) begin
            push(i, 1, 0, 15 - i, 4'b1000, 30 + i);
            @(negedge clk);
            chk("t5_level", DW'(fifo_level), DW'(1));
        end
        @(negedge clk);
        chk("t5_empty", DW'(fifo_level), DW'(0));

        // asynchronous reset with entries queued
        wr_ready = 1'b0;
        push(2, 2, 3, 3, 4'b1111, 40);
        push(2, 2, 3, 1, 4'b0101, 41);
        @(negedge clk);
        chk("t6_level", DW'(fifo_level), DW'(6));
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_valid", DW'(wr_valid), DW'(0));
        chk("t6_rst_level", DW'(fifo_level), DW'(0));
`ifdef GG_DEBLOCK_WB_STATS_EN
        chk("t6_rst_hwm", DW'(stat_hwm), DW'(0));
`endif
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        wr_ready = 1'b1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(negedge clk);
        chk("t6_ovf", DW'(overflow_err), DW'(0));
        chk("t6_in_ready", DW'(in_ready), DW'(1));
        repeat (2) @(negedge clk);

        checking = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
